// File: rtl/vga_timing.sv
// Raster timing generator for the character display: counts a VGA frame, strobes the
// pixel engine, and re-aligns its returned pixel with sync/blank for the DAC pins.
module vga_timing #(
  parameter int   BPP       = 2,
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   H_LEAD    = 8,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter int   PIX_DELAY = 3,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             newline,
  output logic             advance,
  output logic [7:0]       line,
  output logic             frame,
  input  logic [3*BPP-1:0] pixel_in,
  output logic [3*BPP-1:0] rgb,
  output logic             hsync,
  output logic             vsync
);
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_LEAD + H_VISIBLE + H_FRONT;
  localparam int VS_START = V_VISIBLE + V_FRONT;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } tap_t;

  logic [HW-1:0]      hcount, h_nxt;
  logic [VW-1:0]      vcount, v_nxt;
  logic               run;
  logic               vis_nxt;
  tap_t               tap_nxt;
  tap_t [PIX_DELAY:0] vld_pipe;

  // The first clock after reset holds position 0 so the first newline lands on hcount 0.
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    if (run) begin
      h_nxt = hcount + HW'(1);
      v_nxt = vcount;
      if (int'(hcount) == H_TOTAL - 1) begin
        h_nxt = '0;
        v_nxt = (int'(vcount) == V_TOTAL - 1) ? '0 : vcount + VW'(1);
      end
    end
    vis_nxt     = int'(v_nxt) < V_VISIBLE;
    tap_nxt.act = vis_nxt && int'(h_nxt) >= H_LEAD && int'(h_nxt) < H_LEAD + H_VISIBLE;
    tap_nxt.hs  = int'(h_nxt) >= HS_START && int'(h_nxt) < HS_START + H_SYNC;
    tap_nxt.vs  = int'(v_nxt) >= VS_START && int'(v_nxt) < VS_START + V_SYNC;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount   <= '0;
      vcount   <= '0;
      run      <= 1'b0;
      newline  <= 1'b0;
      frame    <= 1'b0;
      line     <= '0;
      vld_pipe <= '0;
      rgb      <= '0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      run         <= 1'b1;
      newline     <= vis_nxt && h_nxt == '0;
      frame       <= int'(v_nxt) == V_VISIBLE && h_nxt == '0;
      line        <= vis_nxt ? 8'(v_nxt >> 1) : '0;
      vld_pipe[0] <= tap_nxt;
      for (int i = 1; i <= PIX_DELAY; i++) vld_pipe[i] <= vld_pipe[i-1];
      // Pixel returns PIX_DELAY clocks after its advance, meeting the tail of the pipe.
      rgb   <= vld_pipe[PIX_DELAY].act ? pixel_in : '0;
      hsync <= vld_pipe[PIX_DELAY].hs ? SYNC_POL : ~SYNC_POL;
      vsync <= vld_pipe[PIX_DELAY].vs ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign advance = vld_pipe[0].act;
endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (reduced geometry, inverted-sync variant, full
// 640x480) checked every clock against an arithmetic raster model driven by elapsed clocks.
`timescale 1ns/1ps
module tb_vga_timing;
  typedef struct {
    int hv, hf, hs, hb, ld, vv, vf, vs, vb, pd;
    bit pol;
  } cfg_t;

  localparam int A_HT   = 64 + 4 + 8 + 12;
  localparam int A_VT   = 16 + 2 + 2 + 3;
  localparam int FA     = A_HT * A_VT;
  localparam int RST1_K = 8 * FA + 19 * A_HT + 81;

  logic clk, rst_n;
  logic a_nl, a_adv, a_fr, a_hs, a_vs, b_nl, b_adv, b_fr, b_hs, b_vs, c_nl, c_adv, c_fr, c_hs, c_vs;
  logic [7:0] a_line, b_line, c_line;
  logic [5:0] pix_a, pix_b, pix_c, a_rgb, b_rgb, c_rgb;
  logic [5:0] hist_a [16];
  logic [5:0] hist_b [16];
  logic [5:0] hist_c [16];

  cfg_t ca, cb, cc;
  int k = -100;
  int epoch = 0;
  int n_chk = 0, n_pass = 0;
  int cnt_nl = 0, cnt_adv = 0, cnt_3f = 0, last_nl = -1;
  int hold = 0, rst2_k, rst2_len;

  vga_timing #(.H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(12), .H_LEAD(8),
               .V_VISIBLE(16), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIX_DELAY(3)) u_a (
    .clk(clk), .rst_n(rst_n), .newline(a_nl), .advance(a_adv), .line(a_line), .frame(a_fr),
    .pixel_in(pix_a), .rgb(a_rgb), .hsync(a_hs), .vsync(a_vs));

  vga_timing #(.H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(12), .H_LEAD(4),
               .V_VISIBLE(16), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIX_DELAY(1),
               .SYNC_POL(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .newline(b_nl), .advance(b_adv), .line(b_line), .frame(b_fr),
    .pixel_in(pix_b), .rgb(b_rgb), .hsync(b_hs), .vsync(b_vs));

  vga_timing u_c (
    .clk(clk), .rst_n(rst_n), .newline(c_nl), .advance(c_adv), .line(c_line), .frame(c_fr),
    .pixel_in(pix_c), .rgb(c_rgb), .hsync(c_hs), .vsync(c_vs));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ht(cfg_t c); return c.hv + c.hf + c.hs + c.hb; endfunction
  function automatic int vt(cfg_t c); return c.vv + c.vf + c.vs + c.vb; endfunction

  // Raster position q (clocks since release) is an active pixel clock.
  function automatic bit in_vis(cfg_t c, int q);
    int h, v;
    if (q < 0) return 1'b0;
    h = q % ht(c);
    v = (q / ht(c)) % vt(c);
    return v < c.vv && h >= c.ld && h < c.ld + c.hv;
  endfunction

  // Expected {newline, advance, frame, line, hsync, vsync, rgb} at clock k (-1 = in reset).
  function automatic logic [18:0] expect_out(cfg_t c, int kk, logic [5:0] prev);
    int h, v, p, hp, vp;
    bit nl, adv, fr, hs, vs;
    logic [7:0] ln;
    logic [5:0] px;
    nl = 0; adv = 0; fr = 0; hs = 0; vs = 0; ln = '0; px = '0;
    if (kk >= 0) begin
      h   = kk % ht(c);
      v   = (kk / ht(c)) % vt(c);
      nl  = v < c.vv && h == 0;
      adv = in_vis(c, kk);
      fr  = v == c.vv && h == 0;
      ln  = (v < c.vv) ? 8'(v / 2) : 8'd0;
    end
    p = kk - c.pd - 1;
    if (p >= 0) begin
      hp = p % ht(c);
      vp = (p / ht(c)) % vt(c);
      hs = hp >= c.ld + c.hv + c.hf && hp < c.ld + c.hv + c.hf + c.hs;
      vs = vp >= c.vv + c.vf && vp < c.vv + c.vf + c.vs;
      if (in_vis(c, p)) px = prev;
    end
    return {nl, adv, fr, ln, hs ? c.pol : ~c.pol, vs ? c.pol : ~c.pol, px};
  endfunction

  function automatic logic [5:0] pick(cfg_t c, int kk, bit fixed);
    bit tag;
    tag = in_vis(c, kk - c.pd);
    if (fixed) return tag ? 6'h3F : 6'h15;
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s k=%0d epoch=%0d got %0h want %0h", nm, k, epoch, act, exp);
  endtask

  always @(posedge clk) begin
    if (!rst_n) k = -1;
    else if (k >= -1) begin
      if (k == -1) epoch++;
      k++;
    end
  end

  always @(negedge clk) begin
    if (k >= -1) begin
      chk("A_outs", {a_nl, a_adv, a_fr, a_line, a_hs, a_vs, a_rgb}, expect_out(ca, k, hist_a[(k-1) & 15]));
      chk("B_outs", {b_nl, b_adv, b_fr, b_line, b_hs, b_vs, b_rgb}, expect_out(cb, k, hist_b[(k-1) & 15]));
      chk("C_outs", {c_nl, c_adv, c_fr, c_line, c_hs, c_vs, c_rgb}, expect_out(cc, k, hist_c[(k-1) & 15]));
      if (k == -1) begin
        chk("A_rst_hs", a_hs, 1); chk("A_rst_vs", a_vs, 1); chk("A_rst_rgb", a_rgb, 0);
        chk("A_rst_nl", a_nl, 0); chk("B_rst_hs", b_hs, 0); chk("C_rst_vs", c_vs, 1);
      end
      if (k == 0) begin
        chk("A_first_nl", a_nl, 1); chk("A_first_line", a_line, 0); chk("C_first_nl", c_nl, 1);
      end
      if (epoch >= 2 && k >= 0 && k <= 3) begin
        chk("A_post_rst_hs", a_hs, 1); chk("A_post_rst_vs", a_vs, 1);
      end
      if (epoch == 1) begin
        if (k == 7)    chk("C_lead_off", c_adv, 0);
        if (k == 8)    chk("C_lead_on", c_adv, 1);
        if (k == 647)  chk("C_adv_last", c_adv, 1);
        if (k == 648)  chk("C_adv_end", c_adv, 0);
        if (k == 667)  chk("C_hs_pre", c_hs, 1);
        if (k == 668)  chk("C_hs_start", c_hs, 0);
        if (k == 763)  chk("C_hs_last", c_hs, 0);
        if (k == 764)  chk("C_hs_end", c_hs, 1);
        if (k == 1599) chk("C_line_v1", c_line, 0);
        if (k == 1600) chk("C_line_v2", c_line, 1);
        if (k == 11)   chk("A_rgb_pre", a_rgb, 0);
        if (k == 12)   chk("A_rgb_first", a_rgb, 6'h3F);
        if (k == 1325) chk("A_line_last", a_line, 7);
        if (k == 1407) chk("A_frame_pre", a_fr, 0);
        if (k == 1408) begin chk("A_frame", a_fr, 1); chk("A_vblank_line", a_line, 0); end
        if (k == 1587) chk("A_vs_pre", a_vs, 1);
        if (k == 1588) chk("A_vs_on", a_vs, 0);
        if (k == 1763) chk("A_vs_last", a_vs, 0);
        if (k == 1764) chk("A_vs_end", a_vs, 1);
        if (k == 3)    chk("B_lead_off", b_adv, 0);
        if (k == 4)    chk("B_lead_on", b_adv, 1);
        if (k == 73)   chk("B_hs_pre", b_hs, 0);
        if (k == 74)   chk("B_hs_on", b_hs, 1);
        if (k == 1585) chk("B_vs_pre", b_vs, 0);
        if (k == 1586) chk("B_vs_on", b_vs, 1);
        if (k >= 0 && k < FA) begin
          cnt_nl  += int'(a_nl);
          cnt_adv += int'(a_adv);
          if (a_rgb == 6'h3F) cnt_3f++;
          if (a_nl) begin
            if (last_nl >= 0) chk("A_nl_spacing", k - last_nl, A_HT);
            last_nl = k;
          end
        end
        if (k == FA) begin
          chk("A_nl_count", cnt_nl, 16); chk("A_adv_count", cnt_adv, 16 * 64);
          chk("A_rgb3f_count", cnt_3f, 16 * 64);
        end
      end
    end
  end

  initial begin
    ca = '{64, 4, 8, 12, 8, 16, 2, 2, 3, 3, 1'b0};
    cb = '{64, 4, 8, 12, 4, 16, 2, 2, 3, 1, 1'b1};
    cc = '{640, 16, 96, 48, 8, 480, 10, 2, 33, 3, 1'b0};
    rst_n = 1'b0;
    pix_a = '0; pix_b = '0; pix_c = '0;
    rst2_k   = int'($urandom_range(3000, 9000));
    rst2_len = int'($urandom_range(1, 4));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 34000; n++) begin
      @(posedge clk);
      #1;
      if (hold > 0) begin
        hold--;
        if (hold == 0) rst_n = 1'b1;
      end else if (epoch == 1 && k == RST1_K) begin
        rst_n = 1'b0; hold = 1;
      end else if (epoch == 2 && k == rst2_k) begin
        rst_n = 1'b0; hold = rst2_len;
      end
      pix_a = pick(ca, k, epoch == 1 && k < FA);
      pix_b = pick(cb, k, epoch == 1 && k < FA);
      pix_c = pick(cc, k, epoch == 1 && k < FA);
      hist_a[k & 15] = pix_a;
      hist_b[k & 15] = pix_b;
      hist_c[k & 15] = pix_c;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
